// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit with valid/ready handshake
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CHK,
    S_DIV,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_funct3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_out_result;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_accept;
  logic              w_load_out;
  logic [XLEN-1:0]   w_result;

  // Multiply: sign-extend to 2*XLEN so the truncated product is exact for all variants
  logic              w_a_sx;
  logic              w_b_sx;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_a_sx    = (r_funct3 != 2'b11) && r_a[XLEN-1];
  assign w_b_sx    = (r_funct3 == 2'b01) && r_b[XLEN-1];
  assign w_a_ext   = {{XLEN{w_a_sx}}, r_a};
  assign w_b_ext   = {{XLEN{w_b_sx}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_funct3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  logic              w_signed;
  logic              w_is_rem;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_special_res;

  assign w_signed  = ~r_funct3[0];
  assign w_is_rem  = r_funct3[1];
  assign w_a_neg   = w_signed & r_a[XLEN-1];
  assign w_b_neg   = w_signed & r_b[XLEN-1];
  assign w_abs_a   = w_a_neg ? -r_a : r_a;
  assign w_abs_b   = w_b_neg ? -r_b : r_b;
  assign w_b_zero  = (r_b == '0);
  assign w_ovf     = w_signed && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (&r_b);
  assign w_special = w_b_zero | w_ovf;
  assign w_special_res = w_b_zero ? (w_is_rem ? r_a : '1)
                                  : (w_is_rem ? '0  : r_a);

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
  assign w_div_res = w_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                              : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign w_accept   = in_ready & in_valid & ~flush;
  assign w_load_out = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = in_funct3[2] ? S_DIV_CHK : S_MUL;
      S_MUL:     w_state_nxt = S_DONE;
      S_DIV_CHK: w_state_nxt = w_special ? S_DONE : S_DIV;
      S_DIV:     if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_result = '0;
    case (r_state)
      S_MUL:     w_result = w_mul_res;
      S_DIV_CHK: w_result = w_special_res;
      S_DIV:     w_result = w_div_res;
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_funct3     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_tag        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvs        <= '0;
      r_cnt        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= in_funct3[1:0];
        r_a      <= in_a;
        r_b      <= in_b;
        r_tag    <= in_tag;
      end
      if (r_state == S_DIV_CHK) begin
        r_rem   <= '0;
        r_quo   <= w_abs_a;
        r_dvs   <= w_abs_b;
        r_cnt   <= CW'(XLEN - 1);
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
      if (r_state == S_DIV) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_load_out) begin
        r_out_result <= w_result;
        r_out_tag    <= r_tag;
      end
    end
  end

endmodule
